// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// unit feeding the Hi/Lo registers; one step per clock, one-cycle done pulse.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div0
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc_hi;   // Booth P_hi / divide remainder R
  logic [DATA_W-1:0] acc_lo;   // Booth P_lo / divide quotient Q
  logic [DATA_W-1:0] opnd;     // b for multiply, |b| for divide
  logic              q_m1;
  logic              sign_a;
  logic              sign_b;
  logic [CW-1:0]     cnt;

  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic              last;

  assign abs_a = a[DATA_W-1] ? -a : a;
  assign abs_b = b[DATA_W-1] ? -b : b;
  assign last  = (cnt == LAST_STEP);

  // Booth step: the extra adder bit keeps the true sign when b = most-negative.
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W-1:0] booth_hi;
  logic [DATA_W-1:0] booth_lo;

  always_comb begin
    booth_sum = {acc_hi[DATA_W-1], acc_hi};
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = {acc_hi[DATA_W-1], acc_hi} + {opnd[DATA_W-1], opnd};
      2'b10:   booth_sum = {acc_hi[DATA_W-1], acc_hi} - {opnd[DATA_W-1], opnd};
      default: booth_sum = {acc_hi[DATA_W-1], acc_hi};
    endcase
    booth_hi = booth_sum[DATA_W:1];
    booth_lo = {booth_sum[0], acc_lo[DATA_W-1:1]};
  end

  // Restoring step on magnitudes; |b| can be 2^(DATA_W-1) so the trial is one bit wider.
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  always_comb begin
    rem_sh = {acc_hi, acc_lo[DATA_W-1]};
    trial  = rem_sh - {1'b0, opnd};
    if (!trial[DATA_W]) begin
      div_r = trial[DATA_W-1:0];
      div_q = {acc_lo[DATA_W-2:0], 1'b1};
    end else begin
      div_r = rem_sh[DATA_W-1:0];
      div_q = {acc_lo[DATA_W-2:0], 1'b0};
    end
    quo_fix = (sign_a ^ sign_b) ? -div_q : div_q;
    rem_fix = sign_a ? -div_r : div_r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      q_m1   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_mult) begin
            acc_hi <= '0;
            acc_lo <= a;
            q_m1   <= 1'b0;
            opnd   <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            div0   <= 1'b0;
            state  <= MULT;
          end else if (start_div) begin
            if (b == '0) begin
              div0  <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              acc_hi <= '0;
              acc_lo <= abs_a;
              opnd   <= abs_b;
              sign_a <= a[DATA_W-1];
              sign_b <= b[DATA_W-1];
              cnt    <= '0;
              busy   <= 1'b1;
              div0   <= 1'b0;
              state  <= DIV;
            end
          end
        end
        MULT: begin
          acc_hi <= booth_hi;
          acc_lo <= booth_lo;
          q_m1   <= acc_lo[0];
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi_out <= booth_hi;
            lo_out <= booth_lo;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        DIV: begin
          acc_hi <= div_r;
          acc_lo <= div_q;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
